// File: rtl/accel_seq_pkg.sv
// accel_seq_pkg: shared op codes, FSM states, lane geometry and ctrl-word packing for the host sequencer
package accel_seq_pkg;
    localparam int LOG_NUM_PU        = 3;
    localparam int LOG_NUM_PE        = 3;
    localparam int MEM_DATA_LEN      = 16;
    localparam int LOG_MEM_NS        = 2;
    localparam int LOG_NUM_MEM_LANES = 4;
    localparam int NUM_MEM_LANES     = 1 << LOG_NUM_MEM_LANES;
    localparam int LOG_PE_LANES      = LOG_NUM_PU + LOG_NUM_PE - LOG_NUM_MEM_LANES;
    localparam int NUM_PE_LANES      = 1 << LOG_PE_LANES;
    localparam int LANE_FLD          = LOG_PE_LANES + 1;
    localparam int MEM_CTRL_W        = LOG_MEM_NS + LANE_FLD * NUM_MEM_LANES;
    localparam int BEAT_W            = MEM_DATA_LEN * NUM_MEM_LANES;

    typedef enum logic [1:0] {OP_LOAD, OP_RUN, OP_READ, OP_NOP} op_e;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_LGAP, S_START, S_RUN, S_EOC, S_RREQ, S_RWAIT, S_RHOLD, S_DONE
    } state_e;

    function automatic logic [MEM_CTRL_W-1:0] build_ctrl(
        input logic [LOG_MEM_NS-1:0]   ns,
        input logic [LOG_PE_LANES-1:0] pe_sel,
        input logic                    valid
    );
        logic [MEM_CTRL_W-1:0] w;
        w = '0;
        w[LOG_MEM_NS-1:0] = ns;
        for (int i = 0; i < NUM_MEM_LANES; i++) w[LOG_MEM_NS + i * LANE_FLD +: LANE_FLD] = {pe_sel, valid};
        return w;
    endfunction
endpackage

// File: rtl/accel_ctrl_encoder.sv
// accel_ctrl_encoder: packs namespace and shared pe_sel into the mem_ctrl_in word, all-zero when idle
module accel_ctrl_encoder
    import accel_seq_pkg::*;
(
    input  logic                    valid_i,
    input  logic [LOG_MEM_NS-1:0]   ns_i,
    input  logic [LOG_PE_LANES-1:0] pe_sel_i,
    output logic [MEM_CTRL_W-1:0]   ctrl_o
);
    // idle cycles present a zero word so the accelerator sees no lane activity
    always_comb ctrl_o = valid_i ? build_ctrl(ns_i, pe_sel_i, 1'b1) : '0;
endmodule

// File: rtl/accel_host_sequencer.sv
// accel_host_sequencer: turns host LOAD/RUN/READ commands into accelerator memory, start and eoc traffic
module accel_host_sequencer
    import accel_seq_pkg::*;
#(
    parameter int TIMEOUT_LEN = 16,
    parameter int RD_LATENCY  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [LOG_MEM_NS-1:0] cmd_ns_i,
    input  logic [15:0]           cmd_len_i,
    input  logic                  din_valid_i,
    output logic                  din_ready_o,
    input  logic [BEAT_W-1:0]     din_data_i,
    output logic                  dout_valid_o,
    input  logic                  dout_ready_i,
    output logic [BEAT_W-1:0]     dout_data_o,
    output logic                  done_o,
    output logic                  err_timeout_o,
    output logic                  mem_rd_wrt_o,
    output logic [MEM_CTRL_W-1:0] mem_ctrl_in_o,
    output logic [BEAT_W-1:0]     mem_data_input_o,
    input  logic [BEAT_W-1:0]     mem_data_output_i,
    output logic                  start_o,
    output logic                  eoc_o,
    input  logic                  eol_i
);
    localparam int LAT_W = RD_LATENCY > 1 ? $clog2(RD_LATENCY) : 1;

    state_e                  state_q, state_d;
    logic [LOG_MEM_NS-1:0]   ns_q, ns_d;
    logic [15:0]             len_q, beat_q, beat_d;
    logic [TIMEOUT_LEN-1:0]  wd_q;
    logic [LAT_W-1:0]        lat_q;
    logic                    accept, load_hs, dout_hs, last_beat, timeout, lat_done, enc_valid;
    logic [LOG_PE_LANES-1:0] enc_pe;
    logic [MEM_CTRL_W-1:0]   enc_ctrl;
    logic                    cmd_ready_q, din_ready_q, dout_valid_q, done_q, err_q, rd_wrt_q, start_q, eoc_q;
    logic [BEAT_W-1:0]       dout_data_q, data_q;
    logic [MEM_CTRL_W-1:0]   ctrl_q;

    accel_ctrl_encoder u_enc (
        .valid_i (enc_valid),
        .ns_i    (ns_d),
        .pe_sel_i(enc_pe),
        .ctrl_o  (enc_ctrl)
    );

    // next-state decode; read requests take pe_sel from the beat about to be issued
    always_comb begin
        accept    = cmd_valid_i & cmd_ready_q;
        load_hs   = din_valid_i & din_ready_q;
        dout_hs   = dout_valid_q & dout_ready_i;
        last_beat = beat_q == len_q - 16'd1;
        timeout   = wd_q == '1;
        lat_done  = lat_q == LAT_W'(RD_LATENCY - 1);
        ns_d      = accept ? cmd_ns_i : ns_q;
        beat_d    = accept ? '0 : (load_hs | dout_hs) ? beat_q + 16'd1 : beat_q;
        state_d   = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = cmd_op_i == OP_RUN ? S_START :
                                           (cmd_op_i == OP_NOP || cmd_len_i == '0) ? S_DONE :
                                           cmd_op_i == OP_LOAD ? S_LOAD : S_RREQ;
            S_LOAD:  if (load_hs && last_beat) state_d = S_LGAP;
            S_LGAP:  state_d = S_DONE;
            S_START: state_d = S_RUN;
            S_RUN:   if (eol_i || timeout) state_d = S_EOC;
            S_EOC:   state_d = S_DONE;
            S_RREQ:  state_d = S_RWAIT;
            S_RWAIT: if (lat_done) state_d = S_RHOLD;
            S_RHOLD: if (dout_hs) state_d = last_beat ? S_DONE : S_RREQ;
            default: state_d = S_IDLE;
        endcase
        enc_valid = load_hs | (state_d == S_RREQ);
        enc_pe    = load_hs ? beat_q[LOG_PE_LANES-1:0] : beat_d[LOG_PE_LANES-1:0];
    end

    // state, counters and every output flop; outputs mirror the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ns_q         <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            wd_q         <= '0;
            lat_q        <= '0;
            cmd_ready_q  <= 1'b0;
            din_ready_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rd_wrt_q     <= 1'b0;
            ctrl_q       <= '0;
            data_q       <= '0;
            start_q      <= 1'b0;
            eoc_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ns_q         <= ns_d;
            len_q        <= accept ? cmd_len_i : len_q;
            beat_q       <= beat_d;
            wd_q         <= state_q == S_RUN ? wd_q + TIMEOUT_LEN'(1) : '0;
            lat_q        <= state_q == S_RWAIT ? lat_q + LAT_W'(1) : '0;
            cmd_ready_q  <= state_d == S_IDLE;
            din_ready_q  <= state_d == S_LOAD;
            dout_valid_q <= state_d == S_RHOLD;
            dout_data_q  <= (state_q == S_RWAIT && lat_done) ? mem_data_output_i : dout_data_q;
            done_q       <= state_d == S_DONE;
            err_q        <= accept ? 1'b0 : (state_q == S_RUN && timeout && !eol_i) ? 1'b1 : err_q;
            rd_wrt_q     <= state_d == S_RREQ;
            ctrl_q       <= enc_ctrl;
            data_q       <= load_hs ? din_data_i : '0;
            start_q      <= state_d == S_START;
            eoc_q        <= state_d == S_EOC;
        end
    end

    assign cmd_ready_o      = cmd_ready_q;
    assign din_ready_o      = din_ready_q;
    assign dout_valid_o     = dout_valid_q;
    assign dout_data_o      = dout_data_q;
    assign done_o           = done_q;
    assign err_timeout_o    = err_q;
    assign mem_rd_wrt_o     = rd_wrt_q;
    assign mem_ctrl_in_o    = ctrl_q;
    assign mem_data_input_o = data_q;
    assign start_o          = start_q;
    assign eoc_o            = eoc_q;
endmodule

// File: doc/accel_host_sequencer.md
Name: accel_host_sequencer

Overview:
Synthesisable host-side sequencer that replaces hand-driven memory/control stimulus for the accelerator top. It accepts host commands (LOAD, RUN, READ), packs streamed data into full-width memory beats, generates the mem_ctrl_in lane/namespace encoding, pulses start/eoc around a run, and returns readback beats. It sits between a host/DMA stream and the accelerator's mem_* / start / eoc / eol pins.

Parameters:
logNumPu, 3, log2 processing units
logNumPe, 3, log2 PEs per PU
memDataLen, 16, bits per memory lane
logMemNamespaces, 2, namespace select width (instruction/data/weight/meta)
logNumMemLanes, 4, log2 memory lanes
timeoutLen, 16, run-watchdog counter width
rdLatency, 1, cycles from read request to valid mem_data_output (>=1)
Derived: numMemLanes=1<<logNumMemLanes; logNumPeMemLanes=logNumPu+logNumPe-logNumMemLanes; numPeMemLanes=1<<logNumPeMemLanes; laneFld=logNumPeMemLanes+1; memCtrlIn=logMemNamespaces+laneFld*numMemLanes (50 at defaults); beatW=memDataLen*numMemLanes (256).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  sequencer idle, accepts command
cmd_op  in  2  0=LOAD, 1=RUN, 2=READ, 3=reserved (accepted, treated as no-op, done pulsed)
cmd_ns  in  logMemNamespaces  target namespace
cmd_len  in  16  beat count (LOAD/READ)
din_valid / din_ready  in/out  1  LOAD data stream handshake
din_data  in  beatW  one beat
dout_valid / dout_ready  out/in  1  readback stream handshake
dout_data  out  beatW  readback beat
done  out  1  one-cycle pulse at command completion
err_timeout  out  1  sticky RUN watchdog error
mem_rd_wrt  out  1  to accelerator
mem_ctrl_in  out  memCtrlIn  to accelerator
mem_data_input  out  beatW  to accelerator
mem_data_output  in  beatW  from accelerator
start  out  1  to accelerator
eoc  out  1  to accelerator
eol  in  1  from accelerator

Behaviour:
- Reset: one clock, synchronous active-high; all outputs 0 except cmd_ready=0 during reset, 1 the cycle after; FSM to IDLE; counters cleared. Reset mid-command aborts immediately, no trailing start/eoc.
- mem_ctrl_in encoding: bits[logMemNamespaces-1:0]=namespace; lane i field at offset logMemNamespaces+i*laneFld = {pe_sel[logNumPeMemLanes-1:0], lane_valid} (valid is LSB). All lanes share pe_sel.
- States: IDLE, LOAD, LGAP, START, RUN, EOC, RREQ, RWAIT, RHOLD, DONE.
- IDLE: cmd_ready=1; accept on cmd_valid&cmd_ready; latch op/ns/len; clear err_timeout on any accept. len=0 for LOAD/READ -> DONE directly, no memory traffic.
- LOAD: din_ready=1. Each din handshake drives, on the next cycle (registered, 1-cycle latency), mem_data_input=din_data, mem_ctrl_in={all lanes valid, pe_sel=beat_idx mod numPeMemLanes, ns}, mem_rd_wrt=0. Non-handshake cycles drive mem_ctrl_in=0. After cmd_len beats -> LGAP.
- LGAP: one cycle, mem_ctrl_in=0, mem_data_input=0 -> DONE.
- RUN cmd: START drives start=1 exactly one cycle; RUN waits for eol, watchdog counts from 0; eol -> EOC; counter reaching all-ones without eol sets err_timeout and -> EOC. EOC drives eoc=1 one cycle -> DONE. eol outside RUN is ignored.
- READ: RREQ drives mem_rd_wrt=1, mem_ctrl_in lanes valid with pe_sel=beat_idx mod numPeMemLanes, one cycle; RWAIT waits rdLatency cycles then captures mem_data_output into dout_data; RHOLD holds dout_valid=1 until dout_ready (backpressure stalls next request); repeat for cmd_len beats -> DONE.
- DONE: done=1 one cycle -> IDLE.
- Beat counters 16-bit; pe_sel wraps modulo numPeMemLanes, beat counter never wraps (len<=65535).

Decomposition:
- Package accel_seq_pkg: op codes, FSM state enum, derived width constants (laneFld, memCtrlIn, beatW), function building mem_ctrl_in from (ns, pe_sel, valid).
- One sub-module: accel_ctrl_encoder (combinational ctrl-word packer, reused by LOAD and READ paths).

Test Plan:
- LOAD ns=2, len=4, beats of 16x0x0001 -> four consecutive mem_ctrl_in words, lane fields 3'b001,011,101,111, low bits 2'b10; then mem_ctrl_in=0; done pulses once.
- LOAD len=8 with din_valid toggling every other cycle -> ctrl nonzero only on handshake cycles, pe_sel 0..3,0..3 in order, no beat lost.
- RUN, eol after 100 cycles -> start high exactly 1 cycle, eoc 1 cycle on the cycle after eol is seen, err_timeout=0.
- RUN with timeoutLen=4, eol never asserted -> after 15 cycles err_timeout=1, eoc pulses, done pulses; next command accept clears err_timeout.
- READ len=4, rdLatency=2, model returns 0x0003 per lane, dout_ready held low 5 cycles on beat 1 -> mem_rd_wrt=1 only in request cycles, 4 beats returned in order, no duplicate requests.
- Reset asserted mid-LOAD (beat 2 of 4) -> next cycle all outputs 0, IDLE, no start/eoc, fresh LOAD behaves normally.
